// File: rtl/mc_control_unit.sv
// Multi-cycle sequencer for the MIPS core: FETCH/DECODE/EXEC/MEM/WB with bounded memory waits.
// Enables are combinational from state and ready inputs, and they are zeroed while rst is high.
module mc_control_unit #(
  parameter int N_INS    = 31,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INS-1:0] ins,
  input  logic             if_equal,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             im_r,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             dm_cs,
  output logic             dm_r,
  output logic             dm_w,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JR, OP_J, OP_JAL
  } op_t;

  localparam logic [1:0] SEL_PC4 = 2'b00;
  localparam logic [1:0] SEL_RS  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;
  localparam logic [1:0] SEL_BR  = 2'b11;

  state_t        cur, nxt;
  op_t           op;
  logic [WW-1:0] wcnt;
  logic          timed_out;
  logic          waiting;
  logic          taken;

  assign state = cur;

  // Multi-hot instruction vectors resolve to the highest-priority class.
  always_comb begin
    op = OP_ALU;
    if      (ins[30]) op = OP_JAL;
    else if (ins[29]) op = OP_J;
    else if (ins[16]) op = OP_JR;
    else if (ins[25]) op = OP_BNE;
    else if (ins[24]) op = OP_BEQ;
    else if (ins[23]) op = OP_SW;
    else if (ins[22]) op = OP_LW;
  end

  assign taken     = (op == OP_BEQ) ? if_equal : ~if_equal;
  assign timed_out = (wcnt == WW'(WAIT_MAX));
  assign waiting   = ((cur == S_FETCH) && !imem_ready) || ((cur == S_MEM) && !dmem_ready);

  always_comb begin
    nxt    = cur;
    im_r   = 1'b0;
    ir_we  = 1'b0;
    pc_we  = 1'b0;
    pc_sel = SEL_PC4;
    rf_we  = 1'b0;
    dm_cs  = 1'b0;
    dm_r   = 1'b0;
    dm_w   = 1'b0;
    unique case (cur)
      S_FETCH: begin
        im_r = 1'b1;
        if (imem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (timed_out) begin
          nxt = S_ERR;
        end
      end
      S_DECODE: begin
        if (ins == '0) begin
          nxt = S_ERR;
        end else begin
          unique case (op)
            OP_JAL: begin pc_we = 1'b1; pc_sel = SEL_JMP; rf_we = 1'b1; nxt = S_FETCH; end
            OP_J:   begin pc_we = 1'b1; pc_sel = SEL_JMP; nxt = S_FETCH; end
            OP_JR:  begin pc_we = 1'b1; pc_sel = SEL_RS;  nxt = S_FETCH; end
            default: nxt = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        unique case (op)
          OP_BEQ, OP_BNE: begin
            pc_we  = 1'b1;
            pc_sel = taken ? SEL_BR : SEL_PC4;
            nxt    = S_FETCH;
          end
          OP_LW, OP_SW: nxt = S_MEM;
          default:      nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dm_cs = 1'b1;
        dm_r  = (op == OP_LW);
        dm_w  = (op == OP_SW);
        if (dmem_ready) begin
          if (op == OP_SW) begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (timed_out) begin
          nxt = S_ERR;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        nxt   = S_FETCH;
      end
      S_ERR:   nxt = S_ERR;
      default: nxt = S_ERR;
    endcase
    // Reset abandons any in-flight access immediately, not at the edge.
    if (rst) begin
      im_r   = 1'b0;
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      pc_sel = SEL_PC4;
      rf_we  = 1'b0;
      dm_cs  = 1'b0;
      dm_r   = 1'b0;
      dm_w   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= S_FETCH;
      wcnt      <= '0;
      err       <= 1'b0;
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      cur <= nxt;
      // Any cycle that is not a stalled FETCH/MEM leaves the counter cleared for the next entry.
      if (waiting) wcnt <= wcnt + WW'(1);
      else         wcnt <= '0;
      if (nxt == S_ERR) err <= 1'b1;
      instr_cnt <= instr_cnt + CNT_W'(pc_we);
      if (cur != S_ERR) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle expected outputs queued by the driver, checked at negedge.
module tb_mc_control_unit;

  localparam int N_INS = 31;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_INS-1:0] ins;
  logic             if_equal, imem_ready, dmem_ready;
  logic             im_r, ir_we, pc_we, rf_we, dm_cs, dm_r, dm_w, err;
  logic [1:0]       pc_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt, cycle_cnt;

  typedef struct packed {
    logic [2:0] st;
    logic       im_r, ir_we, pc_we;
    logic [1:0] sel;
    logic       rf_we, cs, r, w, er;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  localparam logic [N_INS-1:0] I_ALU = 31'd1;
  localparam logic [N_INS-1:0] I_JR  = 31'd1 << 16;
  localparam logic [N_INS-1:0] I_LW  = 31'd1 << 22;
  localparam logic [N_INS-1:0] I_SW  = 31'd1 << 23;
  localparam logic [N_INS-1:0] I_BEQ = 31'd1 << 24;
  localparam logic [N_INS-1:0] I_BNE = 31'd1 << 25;
  localparam logic [N_INS-1:0] I_J   = 31'd1 << 29;
  localparam logic [N_INS-1:0] I_JAL = 31'd1 << 30;

  mc_control_unit #(.N_INS(N_INS), .WAIT_MAX(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ins(ins), .if_equal(if_equal),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .im_r(im_r), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .state(state), .err(err),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] st, input logic im, input logic irw, input logic pcw,
                              input logic [1:0] sel, input logic rfw, input logic cs,
                              input logic r, input logic w, input logic er);
    mk = {st, im, irw, pcw, sel, rfw, cs, r, w, er};
  endfunction

  // Drive one cycle of inputs (just after posedge) and queue the outputs expected in that cycle.
  task automatic cyc(input string tag, input logic r, input logic [N_INS-1:0] i, input logic eq,
                     input logic ir, input logic dr, input obs_t e);
    sb_t s;
    rst = r; ins = i; if_equal = eq; imem_ready = ir; dmem_ready = dr;
    s.tag = tag;
    s.v   = e;
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t s;
      s = sb.pop_front();
      check(s.tag, {18'd0, state, im_r, ir_we, pc_we, pc_sel, rf_we, dm_cs, dm_r, dm_w, err}, {18'd0, s.v});
    end
  end

  task automatic cnts(input string tag, input int ic, input int cc);
    check({tag, "_instr"}, instr_cnt, ic);
    check({tag, "_cycle"}, cycle_cnt, cc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  obs_t o_fetch, o_idle_f, o_dec, o_exec, o_wb, o_zero, o_err;

  initial begin
    o_fetch  = mk(3'd0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    o_idle_f = mk(3'd0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    o_dec    = mk(3'd1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    o_exec   = mk(3'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    o_wb     = mk(3'd4, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0);
    o_zero   = mk(3'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    o_err    = mk(3'd7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);

    rst = 1'b1; ins = '0; if_equal = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_forces_zero", 1, I_ALU, 0, 1, 1, o_zero);
    cnts("after_rst", 0, 0);

    // ALU: 0,1,2,4
    cyc("alu_f", 0, I_ALU, 0, 1, 1, o_fetch);
    cyc("alu_d", 0, I_ALU, 0, 1, 1, o_dec);
    cyc("alu_e", 0, I_ALU, 0, 1, 1, o_exec);
    cyc("alu_wb", 0, I_ALU, 0, 1, 1, o_wb);
    cnts("alu", 1, 4);

    // Branches: taken/not taken, and bne wins over beq when both set
    cyc("beq_t_f", 0, I_BEQ, 1, 1, 1, o_fetch);
    cyc("beq_t_d", 0, I_BEQ, 1, 1, 1, o_dec);
    cyc("beq_t_e", 0, I_BEQ, 1, 1, 1, mk(3'd2, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0));
    cyc("beq_n_f", 0, I_BEQ, 0, 1, 1, o_fetch);
    cyc("beq_n_d", 0, I_BEQ, 0, 1, 1, o_dec);
    cyc("beq_n_e", 0, I_BEQ, 0, 1, 1, mk(3'd2, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    cnts("beq", 3, 10);
    cyc("bne_t_f", 0, I_BNE, 0, 1, 1, o_fetch);
    cyc("bne_t_d", 0, I_BNE, 0, 1, 1, o_dec);
    cyc("bne_t_e", 0, I_BNE, 0, 1, 1, mk(3'd2, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0));
    cyc("prio_f", 0, I_BNE | I_BEQ, 1, 1, 1, o_fetch);
    cyc("prio_d", 0, I_BNE | I_BEQ, 1, 1, 1, o_dec);
    cyc("prio_bne_e", 0, I_BNE | I_BEQ, 1, 1, 1, mk(3'd2, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    cnts("bne", 5, 16);

    // lw with dmem_ready late by 3 cycles
    cyc("lw_f", 0, I_LW, 0, 1, 0, o_fetch);
    cyc("lw_d", 0, I_LW, 0, 1, 0, o_dec);
    cyc("lw_e", 0, I_LW, 0, 1, 0, o_exec);
    for (int k = 0; k < 3; k++)
      cyc("lw_mem_wait", 0, I_LW, 0, 1, 0, mk(3'd3, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0));
    cyc("lw_mem_done", 0, I_LW, 0, 1, 1, mk(3'd3, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0));
    cyc("lw_wb", 0, I_LW, 0, 1, 1, o_wb);
    cnts("lw", 6, 24);

    // Jumps resolve in DECODE; jal beats j when both are set
    cyc("jal_f", 0, I_JAL | I_J, 0, 1, 1, o_fetch);
    cyc("jal_d", 0, I_JAL | I_J, 0, 1, 1, mk(3'd1, 0, 0, 1, 2'b10, 1, 0, 0, 0, 0));
    cyc("j_f", 0, I_J, 0, 1, 1, o_fetch);
    cyc("j_d", 0, I_J, 0, 1, 1, mk(3'd1, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0));
    cyc("jr_f", 0, I_JR | I_SW, 0, 1, 1, o_fetch);
    cyc("jr_d", 0, I_JR | I_SW, 0, 1, 1, mk(3'd1, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0));
    cnts("jumps", 9, 30);

    // sw zero-wait retires from MEM
    cyc("sw_f", 0, I_SW, 0, 1, 1, o_fetch);
    cyc("sw_d", 0, I_SW, 0, 1, 1, o_dec);
    cyc("sw_e", 0, I_SW, 0, 1, 1, o_exec);
    cyc("sw_m", 0, I_SW, 0, 1, 1, mk(3'd3, 0, 0, 1, 2'b00, 0, 1, 0, 1, 0));
    cnts("sw", 10, 34);

    // imem ready exactly at the wait limit is still accepted
    for (int k = 0; k < 15; k++)
      cyc("fetch_wait", 0, I_J, 0, 0, 1, o_idle_f);
    cyc("fetch_last_ok", 0, I_J, 0, 1, 1, o_fetch);
    cyc("fetch_last_d", 0, I_J, 0, 1, 1, mk(3'd1, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0));
    cnts("limit", 11, 51);

    // Reset during a sw data wait abandons the store
    cyc("swr_f", 0, I_SW, 0, 1, 0, o_fetch);
    cyc("swr_d", 0, I_SW, 0, 1, 0, o_dec);
    cyc("swr_e", 0, I_SW, 0, 1, 0, o_exec);
    cyc("swr_m", 0, I_SW, 0, 1, 0, mk(3'd3, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0));
    cyc("swr_rst", 1, I_SW, 0, 1, 1, mk(3'd3, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    check("swr_state", state, 0);
    cnts("swr", 0, 0);

    // imem timeout: 16 stalled FETCH cycles, then sticky ERR with frozen cycle count
    for (int k = 0; k < 16; k++)
      cyc("to_fetch", 0, I_ALU, 0, 0, 0, o_idle_f);
    for (int k = 0; k < 3; k++)
      cyc("to_err", 0, I_ALU, 0, 1, 1, o_err);
    cnts("timeout", 0, 16);

    // Illegal decode
    cyc("ill_rst", 1, '0, 0, 1, 1, o_err);
    cyc("ill_f", 0, '0, 0, 1, 1, o_fetch);
    cyc("ill_d", 0, '0, 0, 1, 1, o_dec);
    cyc("ill_err", 0, '0, 0, 1, 1, o_err);
    cyc("ill_hold", 0, I_ALU, 0, 1, 1, o_err);
    cnts("illegal", 0, 2);

    @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
